// File: rtl/uart_pkg.sv
// Shared definitions for the UART packet-side blocks: FSM states, error codes and
// timeout sizing helpers.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LEN  = 2'd1,
    S_DATA = 2'd2,
    S_CHK  = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CHK  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  // Integer division by baud rate matches how uart_rx derives its bit period.
  function automatic int timeout_cyc(input int clkfreq, input int baudrate, input int bits);
    return bits * (clkfreq / baudrate);
  endfunction

  function automatic int timeout_width(input int cyc);
    return $clog2(cyc + 1);
  endfunction

  localparam int c_timeout_cyc_default = timeout_cyc(100_000_000, 115_200, 20);

endpackage

// File: rtl/uart_rx_pkt_ctrl_if.sv
// Byte stream in from uart_rx, payload buffer writes and frame status out.
// slave is the packet controller, master is whoever feeds and observes it.
interface uart_rx_pkt_ctrl_if;
  logic [7:0] rx_data_i;
  logic       rx_done_tick_i;
  logic [7:0] byte_o;
  logic [3:0] byte_addr_o;
  logic       byte_we_o;
  logic [3:0] pkt_len_o;
  logic       pkt_valid_o;
  logic       pkt_err_o;
  logic [1:0] err_code_o;
  logic       busy_o;

  modport slave (
    input  rx_data_i, rx_done_tick_i,
    output byte_o, byte_addr_o, byte_we_o, pkt_len_o,
    output pkt_valid_o, pkt_err_o, err_code_o, busy_o
  );

  modport master (
    output rx_data_i, rx_done_tick_i,
    input  byte_o, byte_addr_o, byte_we_o, pkt_len_o,
    input  pkt_valid_o, pkt_err_o, err_code_o, busy_o
  );
endinterface

// File: rtl/uart_timeout_cnt.sv
// Idle-cycle counter; expired is a combinational strobe in the cycle the count steps
// onto c_term. clear has priority over enable and suppresses expired.
module uart_timeout_cnt #(
  parameter int c_term  = 17359,
  parameter int c_width = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [c_width-1:0] c_last = c_width'(c_term - 1);

  logic [c_width-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + c_width'(1);
    end
  end

  assign expired = enable && !clear && (cnt == c_last);

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Frames the uart_rx byte stream as SYNC,LEN,payload,CHK; writes payload and reports
// valid/error one cycle after the deciding tick. No backpressure: every tick is consumed.
module uart_rx_pkt_ctrl
  import uart_pkg::*;
#(
  parameter int         c_clkfreq      = 100_000_000,
  parameter int         c_baudrate     = 115_200,
  parameter logic [7:0] c_sync         = 8'h52,
  parameter int         c_timeout_bits = 20
) (
  input logic               clk,
  input logic               rst_i,
  uart_rx_pkt_ctrl_if.slave bus
);

  localparam int c_timeout_cyc = timeout_cyc(c_clkfreq, c_baudrate, c_timeout_bits);
  localparam int c_cnt_w       = timeout_width(c_timeout_cyc);

  state_t     state;
  logic [3:0] len;
  logic [3:0] idx;
  logic [7:0] chk;
  logic       tick;
  logic [7:0] data;
  logic       tmo_clear;
  logic       tmo_expired;

  assign tick      = bus.rx_done_tick_i;
  assign data      = bus.rx_data_i;
  assign tmo_clear = tick || (state == S_IDLE);

  // The counter clears in the tick cycle and the error is registered, so it must
  // step onto c_timeout_cyc-1 for the pulse to land c_timeout_cyc cycles after the tick.
  uart_timeout_cnt #(
    .c_term  (c_timeout_cyc - 1),
    .c_width (c_cnt_w)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst_i),
    .clear   (tmo_clear),
    .enable  (1'b1),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state           <= S_IDLE;
      len             <= '0;
      idx             <= '0;
      chk             <= '0;
      bus.byte_o      <= '0;
      bus.byte_addr_o <= '0;
      bus.byte_we_o   <= 1'b0;
      bus.pkt_len_o   <= '0;
      bus.pkt_valid_o <= 1'b0;
      bus.pkt_err_o   <= 1'b0;
      bus.err_code_o  <= ERR_NONE;
      bus.busy_o      <= 1'b0;
    end else begin
      bus.byte_we_o   <= 1'b0;
      bus.pkt_valid_o <= 1'b0;
      bus.pkt_err_o   <= 1'b0;
      if (tick) begin
        case (state)
          S_IDLE: begin
            if (data == c_sync) begin
              chk        <= c_sync;
              state      <= S_LEN;
              bus.busy_o <= 1'b1;
            end
          end
          S_LEN: begin
            if (data[7:4] != 4'd0 || data == 8'd0) begin
              bus.pkt_err_o  <= 1'b1;
              bus.err_code_o <= ERR_LEN;
              state          <= S_IDLE;
              bus.busy_o     <= 1'b0;
            end else begin
              len   <= data[3:0];
              chk   <= chk ^ data;
              idx   <= '0;
              state <= S_DATA;
            end
          end
          S_DATA: begin
            bus.byte_o      <= data;
            bus.byte_addr_o <= idx;
            bus.byte_we_o   <= 1'b1;
            chk             <= chk ^ data;
            idx             <= idx + 4'd1;
            if (idx == len - 4'd1) begin
              state <= S_CHK;
            end
          end
          S_CHK: begin
            if (data == chk) begin
              bus.pkt_valid_o <= 1'b1;
              bus.pkt_len_o   <= len;
              bus.err_code_o  <= ERR_NONE;
            end else begin
              bus.pkt_err_o  <= 1'b1;
              bus.err_code_o <= ERR_CHK;
            end
            state      <= S_IDLE;
            bus.busy_o <= 1'b0;
          end
        endcase
      end else if (tmo_expired) begin
        bus.pkt_err_o  <= 1'b1;
        bus.err_code_o <= ERR_TMO;
        state          <= S_IDLE;
        bus.busy_o     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed bench: a table of back-to-back byte vectors plus hand sequences for
// timeout, tick-on-expiry and mid-frame reset.
module tb_uart_rx_pkt_ctrl;

  localparam int c_tmo = 17360;

  logic clk = 1'b0;
  logic rst_i;

  uart_rx_pkt_ctrl_if bus ();

  uart_rx_pkt_ctrl dut (
    .clk   (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]  d;
    logic [21:0] exp;
  } vec_t;

  vec_t vecs[24];

  // {we, valid, err, busy, code, len, addr, byte}
  function automatic logic [21:0] mk(input logic we, input logic v, input logic e,
                                     input logic b, input logic [1:0] code,
                                     input logic [3:0] len, input logic [3:0] addr,
                                     input logic [7:0] byt);
    return {we, v, e, b, code, len, addr, byt};
  endfunction

  function automatic logic [21:0] observe();
    return {bus.byte_we_o, bus.pkt_valid_o, bus.pkt_err_o, bus.busy_o, bus.err_code_o,
            bus.pkt_len_o, bus.byte_addr_o, bus.byte_o};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called one time unit after a rising edge; returns one time unit after the
  // edge that samples the tick, so registered responses are visible on return.
  task automatic send(input logic [7:0] b);
    bus.rx_data_i      = b;
    bus.rx_done_tick_i = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_done_tick_i = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   first_err;
    logic err_seen;

    vecs[0]  = '{8'hB5, mk(0,0,0,0,2'd0,4'd0,4'd0,8'h00)};
    vecs[1]  = '{8'h55, mk(0,0,0,0,2'd0,4'd0,4'd0,8'h00)};
    vecs[2]  = '{8'h52, mk(0,0,0,1,2'd0,4'd0,4'd0,8'h00)};
    vecs[3]  = '{8'h02, mk(0,0,0,1,2'd0,4'd0,4'd0,8'h00)};
    vecs[4]  = '{8'hB5, mk(1,0,0,1,2'd0,4'd0,4'd0,8'hB5)};
    vecs[5]  = '{8'h55, mk(1,0,0,1,2'd0,4'd0,4'd1,8'h55)};
    vecs[6]  = '{8'hB0, mk(0,1,0,0,2'd0,4'd2,4'd1,8'h55)};
    vecs[7]  = '{8'h52, mk(0,0,0,1,2'd0,4'd2,4'd1,8'h55)};
    vecs[8]  = '{8'h02, mk(0,0,0,1,2'd0,4'd2,4'd1,8'h55)};
    vecs[9]  = '{8'hB5, mk(1,0,0,1,2'd0,4'd2,4'd0,8'hB5)};
    vecs[10] = '{8'h55, mk(1,0,0,1,2'd0,4'd2,4'd1,8'h55)};
    vecs[11] = '{8'hB1, mk(0,0,1,0,2'd2,4'd2,4'd1,8'h55)};
    vecs[12] = '{8'h52, mk(0,0,0,1,2'd2,4'd2,4'd1,8'h55)};
    vecs[13] = '{8'h00, mk(0,0,1,0,2'd1,4'd2,4'd1,8'h55)};
    vecs[14] = '{8'h52, mk(0,0,0,1,2'd1,4'd2,4'd1,8'h55)};
    vecs[15] = '{8'h12, mk(0,0,1,0,2'd1,4'd2,4'd1,8'h55)};
    vecs[16] = '{8'h52, mk(0,0,0,1,2'd1,4'd2,4'd1,8'h55)};
    vecs[17] = '{8'h01, mk(0,0,0,1,2'd1,4'd2,4'd1,8'h55)};
    vecs[18] = '{8'hAA, mk(1,0,0,1,2'd1,4'd2,4'd0,8'hAA)};
    vecs[19] = '{8'hF9, mk(0,1,0,0,2'd0,4'd1,4'd0,8'hAA)};
    vecs[20] = '{8'h52, mk(0,0,0,1,2'd0,4'd1,4'd0,8'hAA)};
    vecs[21] = '{8'h01, mk(0,0,0,1,2'd0,4'd1,4'd0,8'hAA)};
    vecs[22] = '{8'hAA, mk(1,0,0,1,2'd0,4'd1,4'd0,8'hAA)};
    vecs[23] = '{8'hF9, mk(0,1,0,0,2'd0,4'd1,4'd0,8'hAA)};

    rst_i              = 1'b1;
    bus.rx_data_i      = 8'h00;
    bus.rx_done_tick_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'(observe()), 32'(mk(0,0,0,0,2'd0,4'd0,4'd0,8'h00)));
    rst_i = 1'b0;
    idle_cycle();

    // Sync hunt, valid, bad checksum, bad lengths and two back-to-back frames.
    for (int i = 0; i < 24; i++) begin
      send(vecs[i].d);
      check($sformatf("vec%0d", i), 32'(observe()), 32'(vecs[i].exp));
    end

    // Timeout: last tick (0xB5) in cycle c; the error must first appear in cycle c+c_tmo.
    repeat (4) idle_cycle();
    send(8'h52);
    send(8'h03);
    send(8'hB5);
    first_err = 0;
    for (int i = 1; i <= c_tmo + 8 && first_err == 0; i++) begin
      if (bus.pkt_err_o) first_err = i;
      else idle_cycle();
    end
    check("tmo_latency", 32'(first_err), 32'(c_tmo));
    check("tmo_code_busy", {29'd0, bus.err_code_o, bus.busy_o}, {29'd0, 2'd3, 1'b0});
    idle_cycle();
    check("tmo_pulse_width", {31'd0, bus.pkt_err_o}, 32'd0);

    // Tick landing in the expiry cycle (c+c_tmo-1) must win over the timeout.
    repeat (4) idle_cycle();
    send(8'h52);
    send(8'h03);
    send(8'hB5);
    err_seen = 1'b0;
    for (int i = 1; i < c_tmo - 1; i++) begin
      if (bus.pkt_err_o) err_seen = 1'b1;
      idle_cycle();
    end
    send(8'h55);
    check("expiry_tick_no_err", {31'd0, err_seen | bus.pkt_err_o}, 32'd0);
    check("expiry_tick_write", {28'd0, bus.byte_we_o, bus.busy_o, bus.byte_addr_o[1:0]},
          {28'd0, 1'b1, 1'b1, 2'd1});
    send(8'h00);
    send(8'hB1);
    check("expiry_frame_valid", 32'(observe()), 32'(mk(0,1,0,0,2'd0,4'd3,4'd2,8'h00)));

    // Reset after the LEN byte abandons the frame with no pulse.
    repeat (2) idle_cycle();
    send(8'h52);
    send(8'h02);
    rst_i = 1'b1;
    #1;
    check("midframe_reset", 32'(observe()), 32'(mk(0,0,0,0,2'd0,4'd0,4'd0,8'h00)));
    idle_cycle();
    rst_i = 1'b0;
    idle_cycle();
    send(8'h01);
    check("post_reset_idle", 32'(observe()), 32'(mk(0,0,0,0,2'd0,4'd0,4'd0,8'h00)));
    send(8'h52);
    send(8'h01);
    send(8'hAA);
    check("post_reset_write", 32'(observe()), 32'(mk(1,0,0,1,2'd0,4'd0,4'd0,8'hAA)));
    send(8'hF9);
    check("post_reset_valid", 32'(observe()), 32'(mk(0,1,0,0,2'd0,4'd1,4'd0,8'hAA)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
